// File: rtl/button_event_gen.sv
// Pad button front end: synchronise, debounce and turn each debounced press of
// buttons 7/9/11 into a single-cycle event, serialised so at most one fires per cycle.
module button_event_gen #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       btn_7,
    input  logic       btn_9,
    input  logic       btn_11,
    output logic       event_7,
    output logic       event_9,
    output logic       event_11,
    output logic [2:0] btn_level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       pressRaw;
    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic [2:0]       stable_q;
    logic [2:0]       stable_d;
    logic [2:0]       detect_q;
    logic [2:0]       detect_d;
    logic [2:0]       pending_q;
    logic [2:0]       pending_d;
    logic [2:0]       event_q;
    logic [2:0]       req;
    logic [2:0]       grant;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    assign pressRaw = {btn_11, btn_9, btn_7} ^ {3{ACTIVE_LOW}};

    // Flip the stable level on the edge where the disagreement run would reach
    // DEBOUNCE_CYCLES; any agreeing sample restarts the run.
    always_comb begin
        stable_d = stable_q;
        detect_d = '0;
        cnt_d    = '{default: '0};
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = ~stable_q[i];
                    detect_d[i] = ~stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign req = pending_q | detect_q;

    // Fixed priority 7 > 9 > 11; losers stay pending, repeat requests merge.
    always_comb begin
        grant = '0;
        if (req[0]) begin
            grant = 3'b001;
        end else if (req[1]) begin
            grant = 3'b010;
        end else if (req[2]) begin
            grant = 3'b100;
        end
    end

    assign pending_d = req & ~grant;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            detect_q  <= '0;
            pending_q <= '0;
            event_q   <= '0;
            cnt_q     <= '{default: '0};
        end else begin
            sync1_q   <= pressRaw;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            detect_q  <= detect_d;
            pending_q <= pending_d;
            event_q   <= grant;
            cnt_q     <= cnt_d;
        end
    end

    assign event_7   = event_q[0];
    assign event_9   = event_q[1];
    assign event_11  = event_q[2];
    assign btn_level = stable_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Bench for button_event_gen: directed vector tables, a reset-during-arbitration
// sequence and random button activity checked against a behavioural model.
module tb_button_event_gen;

    localparam int N  = 4;
    localparam int CW = 3;

    typedef struct {
        logic [2:0] btn;
        bit         low;
        logic [2:0] expEv;
        logic [2:0] expLvl;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] raw   = 3'b000;
    logic [2:0] rawL  = 3'b111;
    logic       ev7, ev9, ev11, evL7, evL9, evL11;
    logic [2:0] lvl, lvlL;
    logic [2:0] dutEv, dutEvL;

    int   vectors     = 0;
    int   miscompares = 0;
    vec_t vecs[$];

    // Behavioural model state: recent samples, disagreement runs, outstanding presses.
    bit [2:0] mSamp[$];
    int       mRun[3];
    bit [2:0] mLvl, mDet, mOut, mEv;

    always #5 clock = ~clock;

    assign dutEv  = {ev11, ev9, ev7};
    assign dutEvL = {evL11, evL9, evL7};

    button_event_gen #(.DEBOUNCE_CYCLES(N), .CNT_W(CW), .ACTIVE_LOW(1'b0)) dut (
        .CLK(clock), .RST(reset),
        .btn_7(raw[0]), .btn_9(raw[1]), .btn_11(raw[2]),
        .event_7(ev7), .event_9(ev9), .event_11(ev11),
        .btn_level(lvl)
    );

    button_event_gen #(.DEBOUNCE_CYCLES(N), .CNT_W(CW), .ACTIVE_LOW(1'b1)) dutLow (
        .CLK(clock), .RST(reset),
        .btn_7(rawL[0]), .btn_9(rawL[1]), .btn_11(rawL[2]),
        .event_7(evL7), .event_9(evL9), .event_11(evL11),
        .btn_level(lvlL)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void addVec(input logic [2:0] btn, input bit low,
                                   input logic [2:0] expEv, input logic [2:0] expLvl);
        vec_t v;
        v.btn    = btn;
        v.low    = low;
        v.expEv  = expEv;
        v.expLvl = expLvl;
        vecs.push_back(v);
    endfunction

    function automatic void modelReset();
        mSamp.delete();
        for (int b = 0; b < 3; b++) mRun[b] = 0;
        mLvl = '0;
        mDet = '0;
        mOut = '0;
        mEv  = '0;
    endfunction

    // Advance the model across one rising edge that samples pressed vector p.
    task automatic modelStep(input bit [2:0] p);
        bit [2:0] seen;
        bit [2:0] reqs;
        bit [2:0] rose;
        seen = (mSamp.size() >= 2) ? mSamp[mSamp.size() - 2] : 3'b000;
        mSamp.push_back(p);
        if (mSamp.size() > 4) void'(mSamp.pop_front());
        reqs = mOut | mDet;
        mEv  = '0;
        for (int b = 0; b < 3; b++) begin
            if (reqs[b] && mEv == 3'b000) mEv[b] = 1'b1;
        end
        mOut = reqs & ~mEv;
        rose = '0;
        for (int b = 0; b < 3; b++) begin
            mRun[b] = (seen[b] != mLvl[b]) ? mRun[b] + 1 : 0;
            if (mRun[b] == N) begin
                mLvl[b] = ~mLvl[b];
                mRun[b] = 0;
                rose[b] = mLvl[b];
            end
        end
        mDet = rose;
    endtask

    task automatic resetDut();
        @(negedge clock);
        reset = 1'b1;
        raw   = 3'b000;
        rawL  = 3'b111;
        #1;
        checkOutput("resetEv", dutEv, 0);
        checkOutput("resetLvl", lvl, 0);
        checkOutput("resetEvLow", dutEvL, 0);
        checkOutput("resetLvlLow", lvlL, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        modelReset();
    endtask

    // Applies and checks every queued row, then empties the table.
    task automatic applyStimulus(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            if (vecs[i].low) begin
                rawL = vecs[i].btn;
                raw  = 3'b000;
            end else begin
                raw  = vecs[i].btn;
                rawL = 3'b111;
            end
            @(posedge clock);
            #1;
            if (vecs[i].low) begin
                checkOutput($sformatf("%s[%0d].ev", tag, i), dutEvL, vecs[i].expEv);
                checkOutput($sformatf("%s[%0d].lvl", tag, i), lvlL, vecs[i].expLvl);
                checkOutput($sformatf("%s[%0d].quiet", tag, i), dutEv, 0);
            end else begin
                checkOutput($sformatf("%s[%0d].ev", tag, i), dutEv, vecs[i].expEv);
                checkOutput($sformatf("%s[%0d].lvl", tag, i), lvl, vecs[i].expLvl);
                checkOutput($sformatf("%s[%0d].quiet", tag, i), dutEvL, 0);
            end
        end
        vecs.delete();
    endtask

    initial begin
        int firstEdge[3];
        int evCount[3];

        resetDut();

        // Press, release after N+2 edges with no event, then a second press.
        for (int k = 0; k <= 7; k++)
            addVec(3'b001, 1'b0, (k == 6) ? 3'b001 : 3'b000, (k >= 5) ? 3'b001 : 3'b000);
        for (int k = 8; k <= 13; k++)
            addVec(3'b000, 1'b0, 3'b000, (k < 13) ? 3'b001 : 3'b000);
        for (int k = 14; k <= 21; k++)
            addVec(3'b001, 1'b0, (k == 20) ? 3'b001 : 3'b000, (k >= 19) ? 3'b001 : 3'b000);
        applyStimulus("basic");

        resetDut();
        for (int k = 0; k <= 9; k++)
            addVec(3'b111, 1'b0,
                   (k == 6) ? 3'b001 : (k == 7) ? 3'b010 : (k == 8) ? 3'b100 : 3'b000,
                   (k >= 5) ? 3'b111 : 3'b000);
        applyStimulus("simul");

        resetDut();
        for (int k = 0; k <= 12; k++)
            addVec((k == 1 || k == 3) ? 3'b000 : 3'b010, 1'b0,
                   (k == 10) ? 3'b010 : 3'b000, (k >= 9) ? 3'b010 : 3'b000);
        applyStimulus("bounce");

        resetDut();
        for (int k = 0; k <= 7; k++)
            addVec(3'b111, 1'b1, 3'b000, 3'b000);
        for (int k = 0; k <= 9; k++)
            addVec(3'b011, 1'b1, (k == 6) ? 3'b100 : 3'b000, (k >= 5) ? 3'b100 : 3'b000);
        applyStimulus("actLow");

        // Reset while 9 and 11 are still pending; held buttons must re-fire once each.
        resetDut();
        @(negedge clock);
        raw = 3'b111;
        repeat (7) @(posedge clock);
        #1;
        checkOutput("midEv7", dutEv, 3'b001);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midRstEv", dutEv, 0);
        checkOutput("midRstLvl", lvl, 0);
        @(negedge clock);
        reset = 1'b0;
        for (int b = 0; b < 3; b++) begin
            firstEdge[b] = -1;
            evCount[b]   = 0;
        end
        for (int k = 0; k < 14; k++) begin
            @(posedge clock);
            #1;
            for (int b = 0; b < 3; b++) begin
                if (dutEv[b]) begin
                    evCount[b]++;
                    if (firstEdge[b] < 0) firstEdge[b] = k;
                end
            end
        end
        checkOutput("midFirst7", firstEdge[0], N + 2);
        checkOutput("midFirst9", firstEdge[1], N + 3);
        checkOutput("midFirst11", firstEdge[2], N + 4);
        for (int b = 0; b < 3; b++)
            checkOutput($sformatf("midCount%0d", b), evCount[b], 1);

        resetDut();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clock);
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
                #1;
                checkOutput("rndRstEv", dutEv, 0);
                checkOutput("rndRstLvl", lvl, 0);
                @(negedge clock);
                reset = 1'b0;
                modelReset();
            end
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 7) == 0) raw[b] = ~raw[b];
            end
            modelStep(raw);
            @(posedge clock);
            #1;
            checkOutput("rndEv", dutEv, mEv);
            checkOutput("rndLvl", lvl, mLvl);
            checkOutput("rndQuietLow", dutEvL, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
